// File: rtl/mdu_iter.sv
// ---------------------------------------------------------------------------
// mdu_iter
// Iterative RV32M multiply/divide unit placed between the register file read
// ports and the write port. One bit of the operation is resolved per clock
// (radix-2), so a normal operation keeps the unit busy for DATA_WIDTH cycles.
// Divide-by-zero and signed divide overflow finish in a single cycle.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset, aborts any operation in flight
//   start   in   operation request, only looked at while busy is low
//   funct3  in   0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   op1     in   rs1 value (multiplicand / dividend)
//   op2     in   rs2 value (multiplier / divisor)
//   rd_in   in   destination register index
//   busy    out  an iterative operation is running
//   done    out  one-cycle pulse, result and rd_out valid
//   result  out  final value, held until the next done
//   rd_out  out  destination captured at start, held until the next done
//   we      out  register file write enable (done and rd_out != 0)
// ---------------------------------------------------------------------------
module mdu_iter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               funct3,
    input  logic [DATA_WIDTH-1:0]    op1,
    input  logic [DATA_WIDTH-1:0]    op2,
    input  logic [ADDRESS_WIDTH-1:0] rd_in,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    output logic [ADDRESS_WIDTH-1:0] rd_out,
    output logic                     we
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(DATA_WIDTH);
    localparam logic [W-1:0]  MIN_NEG    = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Latched operation context
    logic [2:0]               f3_q;
    logic                     neg_q;
    logic [ADDRESS_WIDTH-1:0] rd_q;
    logic [W-1:0]             opnd_q;
    logic [2*W-1:0]           acc;
    logic [CW-1:0]            count;

    // Accept-time decode
    logic          accept;
    logic          is_div;
    logic          op1_signed;
    logic          op2_signed;
    logic          op1_neg;
    logic          op2_neg;
    logic [W-1:0]  mag1;
    logic [W-1:0]  mag2;
    logic          div_by_zero;
    logic          div_overflow;
    logic          fast;
    logic [W-1:0]  fast_result;

    // Iteration datapath
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] acc_step;
    logic [2*W-1:0] prod_signed;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic [W-1:0]   final_result;
    logic [CW-1:0]  count_inc;
    logic           last_iter;

    // A new request is taken whenever no iteration is running, which includes
    // the done cycle so that back-to-back operations have no bubble.
    assign accept = start && (state != RUN);

    // Operand decode: signedness per funct3, magnitudes for the unsigned core,
    // and detection of the divide cases that never enter the iterative loop.
    always_comb begin
        is_div       = funct3[2];
        op1_signed   = (funct3 == 3'd1) || (funct3 == 3'd2) ||
                       (funct3 == 3'd4) || (funct3 == 3'd6);
        op2_signed   = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        op1_neg      = op1_signed && op1[W-1];
        op2_neg      = op2_signed && op2[W-1];
        mag1         = op1_neg ? -op1 : op1;
        mag2         = op2_neg ? -op2 : op2;
        div_by_zero  = is_div && (op2 == '0);
        div_overflow = is_div && !funct3[0] && (op1 == MIN_NEG) && (op2 == '1);
        fast         = div_by_zero || div_overflow;
        fast_result  = '0;
        if (div_by_zero) begin
            fast_result = funct3[1] ? op1 : '1;
        end else if (div_overflow) begin
            fast_result = funct3[1] ? '0 : MIN_NEG;
        end
    end

    // One radix-2 step. Multiply: acc holds {partial high, remaining multiplier}
    // and shifts right. Divide (restoring): acc holds {remainder, dividend/quotient}
    // and shifts left; the borrow out of the trial subtraction picks the quotient bit.
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc[W-1:1]};
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!div_diff[W]) begin
            div_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
        end else begin
            div_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
        end
        acc_step  = f3_q[2] ? div_next : mul_next;
        count_inc = count + CW'(1);
        last_iter = (count_inc == COUNT_LAST);
    end

    // Sign correction applied to the value produced by the final iteration.
    // MUL never sets neg_q, so its low half passes through unchanged.
    always_comb begin
        prod_signed = neg_q ? -acc_step : acc_step;
        quo         = acc_step[W-1:0];
        rem         = acc_step[2*W-1:W];
        case (f3_q)
            3'd0:         final_result = prod_signed[W-1:0];
            3'd1, 3'd2,
            3'd3:         final_result = prod_signed[2*W-1:W];
            3'd4, 3'd5:   final_result = neg_q ? -quo : quo;
            default:      final_result = neg_q ? -rem : rem;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = fast ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = fast ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        we = done && (rd_out != '0);
    end

    // Datapath registers. result/rd_out are only written when an operation
    // completes so the write port sees stable values between done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q   <= '0;
            neg_q  <= 1'b0;
            rd_q   <= '0;
            opnd_q <= '0;
            acc    <= '0;
            count  <= '0;
            result <= '0;
            rd_out <= '0;
        end else if (accept) begin
            f3_q   <= funct3;
            rd_q   <= rd_in;
            count  <= '0;
            neg_q  <= funct3[2] && funct3[1] ? op1_neg : (op1_neg ^ op2_neg);
            if (is_div) begin
                opnd_q <= mag2;
                acc    <= {{W{1'b0}}, mag1};
            end else begin
                opnd_q <= mag1;
                acc    <= {{W{1'b0}}, mag2};
            end
            if (fast) begin
                result <= fast_result;
                rd_out <= rd_in;
            end
        end else if (state == RUN) begin
            acc   <= acc_step;
            count <= count_inc;
            if (last_iter) begin
                result <= final_result;
                rd_out <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// ---------------------------------------------------------------------------
// tb_mdu_iter
// Self-checking bench for mdu_iter. Expected results come from a reference
// model using 64-bit integer arithmetic on the RV32M rules; expected latency
// is one cycle for the divide special cases and 33 cycles otherwise.
// ---------------------------------------------------------------------------
module tb_mdu_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we;

    int compared;
    int mismatched;

    mdu_iter #(
        .DATA_WIDTH(32),
        .ADDRESS_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .funct3(funct3),
        .op1(op1),
        .op2(op2),
        .rd_in(rd_in),
        .busy(busy),
        .done(done),
        .result(result),
        .rd_out(rd_out),
        .we(we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic following the RV32M definitions
    function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        int          ia;
        int          ib;
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3 >= 3'd4 && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Operand generator biased toward the interesting corners
    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    // Present a request on the current (negedge) cycle, let one rising edge
    // accept it, and return at the following negedge with start released.
    task automatic launch(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        funct3 = f3;
        op1    = a;
        op2    = b;
        rd_in  = rd;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Count cycles (starting at 1 on the current negedge) until done is seen,
    // bounded so a stuck design still reaches the summary.
    task automatic wait_done(output logic [31:0] res, output logic [4:0] rdo,
                             output logic weo, output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        res = result;
        rdo = rd_out;
        weo = we;
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         output logic [31:0] res, output logic [4:0] rdo,
                         output logic weo, output int lat, output int bcnt);
        @(negedge clk);
        launch(f3, a, b, rd);
        wait_done(res, rdo, weo, lat, bcnt);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compared += 5;
        if (busy !== 1'b0)    begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0)    begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        if (we !== 1'b0)      begin mismatched++; $display("[TB] FAIL reset_we: got %b expected 0", we); end
        if (result !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
        if (rd_out !== 5'd0)  begin mismatched++; $display("[TB] FAIL reset_rd_out: got %0d expected 0", rd_out); end
    endtask

    task automatic test_mul_basic();
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        weo;
        int          lat;
        int          bcnt;
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, res, rdo, weo, lat, bcnt);
        compared += 5;
        if (res !== 32'hFFFF_FFEB) begin mismatched++; $display("[TB] FAIL mul_result: got %h expected ffffffeb", res); end
        if (weo !== 1'b1)          begin mismatched++; $display("[TB] FAIL mul_we: got %b expected 1", weo); end
        if (rdo !== 5'd5)          begin mismatched++; $display("[TB] FAIL mul_rd_out: got %0d expected 5", rdo); end
        if (lat !== 33)            begin mismatched++; $display("[TB] FAIL mul_latency: got %0d expected 33", lat); end
        if (bcnt !== 32)           begin mismatched++; $display("[TB] FAIL mul_busy_cycles: got %0d expected 32", bcnt); end
        @(negedge clk);
        compared += 2;
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL mul_done_pulse: got %b expected 0", done); end
        if (result !== 32'hFFFF_FFEB) begin mismatched++; $display("[TB] FAIL mul_result_hold: got %h expected ffffffeb", result); end
    endtask

    task automatic test_mulh();
        logic [2:0]  f3v [3];
        logic [31:0] av  [3];
        logic [31:0] bv  [3];
        logic [31:0] ev  [3];
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        weo;
        int          lat;
        int          bcnt;
        f3v[0] = 3'd1; av[0] = 32'h8000_0000; bv[0] = 32'h8000_0000; ev[0] = 32'h4000_0000;
        f3v[1] = 3'd3; av[1] = 32'hFFFF_FFFF; bv[1] = 32'hFFFF_FFFF; ev[1] = 32'hFFFF_FFFE;
        f3v[2] = 3'd2; av[2] = 32'hFFFF_FFFF; bv[2] = 32'hFFFF_FFFF; ev[2] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            do_op(f3v[i], av[i], bv[i], 5'd9, res, rdo, weo, lat, bcnt);
            compared += 2;
            if (res !== ev[i]) begin mismatched++; $display("[TB] FAIL mulh_case%0d: got %h expected %h", i, res, ev[i]); end
            if (lat !== 33)    begin mismatched++; $display("[TB] FAIL mulh_latency%0d: got %0d expected 33", i, lat); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3v [8];
        logic [31:0] av  [8];
        logic [31:0] bv  [8];
        logic [31:0] ev  [8];
        int          lv  [8];
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        weo;
        int          lat;
        int          bcnt;
        f3v[0] = 3'd4; av[0] = 32'hFFFF_FFF9; bv[0] = 32'd2; ev[0] = 32'hFFFF_FFFD; lv[0] = 33;
        f3v[1] = 3'd6; av[1] = 32'hFFFF_FFF9; bv[1] = 32'd2; ev[1] = 32'hFFFF_FFFF; lv[1] = 33;
        f3v[2] = 3'd5; av[2] = 32'd100; bv[2] = 32'd7; ev[2] = 32'd14; lv[2] = 33;
        f3v[3] = 3'd7; av[3] = 32'd100; bv[3] = 32'd7; ev[3] = 32'd2;  lv[3] = 33;
        f3v[4] = 3'd4; av[4] = 32'd5; bv[4] = 32'd0; ev[4] = 32'hFFFF_FFFF; lv[4] = 1;
        f3v[5] = 3'd7; av[5] = 32'd5; bv[5] = 32'd0; ev[5] = 32'd5; lv[5] = 1;
        f3v[6] = 3'd4; av[6] = 32'h8000_0000; bv[6] = 32'hFFFF_FFFF; ev[6] = 32'h8000_0000; lv[6] = 1;
        f3v[7] = 3'd6; av[7] = 32'h8000_0000; bv[7] = 32'hFFFF_FFFF; ev[7] = 32'd0; lv[7] = 1;
        for (int i = 0; i < 8; i++) begin
            do_op(f3v[i], av[i], bv[i], 5'd12, res, rdo, weo, lat, bcnt);
            compared += 3;
            if (res !== ev[i])     begin mismatched++; $display("[TB] FAIL div_case%0d: got %h expected %h", i, res, ev[i]); end
            if (lat !== lv[i])     begin mismatched++; $display("[TB] FAIL div_latency%0d: got %0d expected %0d", i, lat, lv[i]); end
            if (bcnt !== lv[i]-1)  begin mismatched++; $display("[TB] FAIL div_busy%0d: got %0d expected %0d", i, bcnt, lv[i]-1); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        int          exp_lat;
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        weo;
        int          lat;
        int          bcnt;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom_range(0, 31));
            exp_res = ref_model(f3, a, b);
            exp_lat = ref_latency(f3, a, b);
            do_op(f3, a, b, rd, res, rdo, weo, lat, bcnt);
            compared += 4;
            if (res !== exp_res) begin mismatched++; $display("[TB] FAIL rand%0d_result f3=%0d a=%h b=%h: got %h expected %h", i, f3, a, b, res, exp_res); end
            if (lat !== exp_lat) begin mismatched++; $display("[TB] FAIL rand%0d_latency f3=%0d: got %0d expected %0d", i, f3, lat, exp_lat); end
            if (rdo !== rd)      begin mismatched++; $display("[TB] FAIL rand%0d_rd_out: got %0d expected %0d", i, rdo, rd); end
            if (weo !== (rd != 0)) begin mismatched++; $display("[TB] FAIL rand%0d_we: got %b expected %b", i, weo, rd != 0); end
        end
    endtask

    task automatic test_ignore_while_busy();
        logic [31:0] exp_res;
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        weo;
        int          lat;
        int          bcnt;
        exp_res = ref_model(3'd0, 32'd123457, 32'hFFFF_FF9D);
        @(negedge clk);
        launch(3'd0, 32'd123457, 32'hFFFF_FF9D, 5'd7);
        funct3 = 3'd5;
        op1    = $urandom;
        op2    = 32'd3;
        rd_in  = 5'd3;
        start  = 1'b1;
        repeat (5) @(negedge clk);
        start  = 1'b0;
        op1    = $urandom;
        wait_done(res, rdo, weo, lat, bcnt);
        compared += 3;
        if (res !== exp_res) begin mismatched++; $display("[TB] FAIL ignore_result: got %h expected %h", res, exp_res); end
        if (rdo !== 5'd7)    begin mismatched++; $display("[TB] FAIL ignore_rd_out: got %0d expected 7", rdo); end
        if (lat !== 28)      begin mismatched++; $display("[TB] FAIL ignore_latency: got %0d expected 28", lat); end
        @(negedge clk);
        compared += 2;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL ignore_no_queue_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL ignore_no_queue_done: got %b expected 0", done); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        weo;
        int          lat;
        int          bcnt;
        do_op(3'd1, $urandom, $urandom, 5'd1, res, rdo, weo, lat, bcnt);
        a = $urandom;
        b = 32'($urandom_range(1, 1000));
        exp_res = ref_model(3'd5, a, b);
        launch(3'd5, a, b, 5'd2);
        wait_done(res, rdo, weo, lat, bcnt);
        compared += 4;
        if (res !== exp_res) begin mismatched++; $display("[TB] FAIL b2b_result: got %h expected %h", res, exp_res); end
        if (lat !== 33)      begin mismatched++; $display("[TB] FAIL b2b_latency: got %0d expected 33", lat); end
        if (bcnt !== 32)     begin mismatched++; $display("[TB] FAIL b2b_busy: got %0d expected 32", bcnt); end
        if (rdo !== 5'd2)    begin mismatched++; $display("[TB] FAIL b2b_rd_out: got %0d expected 2", rdo); end
        launch(3'd6, 32'd77, 32'd0, 5'd4);
        wait_done(res, rdo, weo, lat, bcnt);
        compared += 2;
        if (res !== 32'd77) begin mismatched++; $display("[TB] FAIL b2b_fast_result: got %h expected 0000004d", res); end
        if (lat !== 1)      begin mismatched++; $display("[TB] FAIL b2b_fast_latency: got %0d expected 1", lat); end
        a = $urandom;
        b = $urandom;
        exp_res = ref_model(3'd0, a, b);
        launch(3'd0, a, b, 5'd6);
        wait_done(res, rdo, weo, lat, bcnt);
        compared += 2;
        if (res !== exp_res) begin mismatched++; $display("[TB] FAIL b2b_after_fast_result: got %h expected %h", res, exp_res); end
        if (lat !== 33)      begin mismatched++; $display("[TB] FAIL b2b_after_fast_latency: got %0d expected 33", lat); end
    endtask

    task automatic test_abort_and_rd_zero();
        int          dones;
        logic [31:0] exp_res;
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        weo;
        int          lat;
        int          bcnt;
        @(negedge clk);
        launch(3'd0, 32'd1234, 32'd5678, 5'd8);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compared += 5;
        if (busy !== 1'b0)    begin mismatched++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        if (done !== 1'b0)    begin mismatched++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
        if (we !== 1'b0)      begin mismatched++; $display("[TB] FAIL abort_we: got %b expected 0", we); end
        if (result !== 32'd0) begin mismatched++; $display("[TB] FAIL abort_result: got %h expected 0", result); end
        if (rd_out !== 5'd0)  begin mismatched++; $display("[TB] FAIL abort_rd_out: got %0d expected 0", rd_out); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        compared++;
        if (dones !== 0) begin mismatched++; $display("[TB] FAIL abort_activity: got %0d expected 0", dones); end
        exp_res = ref_model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        do_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, res, rdo, weo, lat, bcnt);
        compared += 4;
        if (lat !== 33)      begin mismatched++; $display("[TB] FAIL rd0_latency: got %0d expected 33", lat); end
        if (weo !== 1'b0)    begin mismatched++; $display("[TB] FAIL rd0_we: got %b expected 0", weo); end
        if (rdo !== 5'd0)    begin mismatched++; $display("[TB] FAIL rd0_rd_out: got %0d expected 0", rdo); end
        if (res !== exp_res) begin mismatched++; $display("[TB] FAIL rd0_result: got %h expected %h", res, exp_res); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        start      = 1'b0;
        funct3     = 3'd0;
        op1        = 32'd0;
        op2        = 32'd0;
        rd_in      = 5'd0;
        test_reset();
        test_mul_basic();
        test_mulh();
        test_div();
        test_random();
        test_ignore_while_busy();
        test_back_to_back();
        test_abort_and_rd_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
